fft_frame_loader: RTL and testbench
===================================

FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 Parameter: DATA_W, default 16, width of each real and imaginary sample.
REQ-002 Parameter: N, default 16, samples per frame; only 16 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_ready  output  1  loader can accept a sample this cycle.
REQ-007 s_real  input  DATA_W  sample real part, two's complement.
REQ-008 s_im  input  DATA_W  sample imaginary part, two's complement.
REQ-009 s_last  input  1  upstream marks the final sample of a frame.
REQ-010 frame_real  output  N*DATA_W  real parts of the frame in natural order; sample k at bits [k*DATA_W +: DATA_W].
REQ-011 frame_im  output  N*DATA_W  imaginary parts of the frame, same packing as frame_real.
REQ-012 frame_valid  output  1  frame_real/frame_im hold a complete, unconsumed frame.
REQ-013 frame_ready  input  1  downstream (FFT wrapper) takes the frame this cycle.
REQ-014 frame_count  output  8  number of frames committed, modulo 256.
REQ-015 err_len  output  1  sticky flag: frame-length violation seen.

Function
REQ-016 Sample handshake: a sample is accepted in a cycle with s_valid && s_ready; no other cycle changes the write buffer.
REQ-017 Frame handshake: a frame is consumed in a cycle with frame_valid && frame_ready; frame_real/frame_im are stable while frame_valid=1 and the frame is not consumed.
REQ-018 Storage: one write buffer of 16 complex samples plus a 4-bit write index wr_idx; one output register bank driving frame_real/frame_im.
REQ-019 Each accepted sample is stored at position wr_idx, and wr_idx then increments.
REQ-020 States: LOAD (s_ready=1) and WAIT (s_ready=0); reset enters LOAD.
REQ-021 LOAD, accept with wr_idx<15 and s_last=0: store the sample, increment wr_idx, stay in LOAD.
REQ-022 LOAD, accept with wr_idx=15 and the output bank free (frame_valid=0, or consumed this cycle): at the same edge, load the output bank from the 15 buffered samples plus the current sample.
  - Also in that edge: frame_valid=1, wr_idx=0, frame_count+1, stay in LOAD.
  - Latency: frame_valid is high in the cycle after the 16th accept.
REQ-023 LOAD, accept with wr_idx=15 and the output bank occupied and not consumed: store the sample and go to WAIT.
REQ-024 WAIT, frame consumed: load the output bank from the write buffer, frame_valid stays 1, wr_idx=0, frame_count+1, go to LOAD.
REQ-025 WAIT, frame not consumed: hold all state; input samples are not accepted.
REQ-026 Consumption with no new frame committing in the same cycle: frame_valid=0 at the next edge; frame_real/frame_im keep their last value.
REQ-027 Sustained throughput: one sample per cycle with no bubble whenever the consumer takes each frame within 16 cycles of frame_valid rising.
REQ-028 Early s_last (accept with s_last=1 and wr_idx<15):
  - the partial frame is discarded and wr_idx=0;
  - err_len=1;
  - no commit occurs and frame_count is unchanged.
REQ-029 Missing s_last (accept with wr_idx=15 and s_last=0): the frame commits normally and err_len=1.
REQ-030 frame_count wraps from 255 to 0.
REQ-031 err_len clears only on reset.
REQ-032 No arithmetic is performed on sample data; samples pass through bit-exact.

Reset
REQ-033 While rst=1 at a clock edge, the loader enters LOAD with wr_idx=0, frame_valid=0, frame_count=0, err_len=0, and frame_real/frame_im cleared to all zeros.
REQ-034 Outputs during and immediately after reset: s_ready=1 in the cycle after the reset edge; s_ready=0 is never driven while rst=1.
REQ-035 Reset mid-frame or in WAIT discards buffered samples and any pending frame; the first accept after reset is sample 0.
REQ-036 Reset has priority over a simultaneous accept or consume.

Verification
REQ-037 Reset, then 16 accepts (real=k, im=-k for k=0..15, s_last on k=15), frame_ready=0 -> next cycle frame_valid=1, slice 3 real=3 im=0xFFFD, frame_count=1, err_len=0.
REQ-038 Continuous stream of 3 frames with frame_ready=1 -> s_ready never drops; frame_valid high from cycle 17; frame_count=3; frames bit-exact.
REQ-039 Frame 1 held (frame_ready=0), frame 2 fully sent -> s_ready=0 after 16th accept of frame 2; frame 1 outputs unchanged; on the frame_ready pulse, frame 2 appears next cycle and s_ready=1.
REQ-040 s_last on 5th sample, then 16 clean samples -> err_len=1; only the clean frame commits, frame_count=1; its sample 0 is the 6th sent.
REQ-041 rst asserted in WAIT with frame_valid=1 -> next cycle frame_valid=0, s_ready=1, frame_count=0; the next 16 accepts form a correct frame.
REQ-042 257 frames committed -> frame_count=1.

Source files
------------

// File: rtl/fft_frame_loader.sv
// Collects a stream of complex samples into 16-sample frames and hands each
// complete frame to the FFT wrapper through a single output register bank.
module fft_frame_loader #(
  parameter int DATA_W = 16,
  parameter int N      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_real,
  input  logic [DATA_W-1:0]   s_im,
  input  logic                s_last,
  output logic [N*DATA_W-1:0] frame_real,
  output logic [N*DATA_W-1:0] frame_im,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [7:0]          frame_count,
  output logic                err_len
);

  typedef enum logic {ST_LOAD, ST_WAIT} state_t;

  state_t              state;
  logic [DATA_W-1:0]   wbuf_real [N];
  logic [DATA_W-1:0]   wbuf_im   [N];
  logic [3:0]          wr_idx;
  logic                accept;
  logic                consume;
  logic                last_slot;
  logic [N*DATA_W-1:0] commit_real;
  logic [N*DATA_W-1:0] commit_im;

  // rst forces ready high so upstream never sees a stall while resetting
  assign s_ready   = (state == ST_LOAD) || rst;
  assign accept    = s_valid && s_ready;
  assign consume   = frame_valid && frame_ready;
  assign last_slot = (wr_idx == 4'(N - 1));

  // In LOAD the 16th sample bypasses the buffer straight into the output bank
  always_comb begin
    commit_real = '0;
    commit_im   = '0;
    for (int k = 0; k < N; k++) begin
      commit_real[k*DATA_W +: DATA_W] = wbuf_real[k];
      commit_im[k*DATA_W +: DATA_W]   = wbuf_im[k];
    end
    if (state == ST_LOAD) begin
      commit_real[(N-1)*DATA_W +: DATA_W] = s_real;
      commit_im[(N-1)*DATA_W +: DATA_W]   = s_im;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept && state == ST_LOAD) begin
      wbuf_real[wr_idx] <= s_real;
      wbuf_im[wr_idx]   <= s_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOAD;
      wr_idx      <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      err_len     <= 1'b0;
      frame_real  <= '0;
      frame_im    <= '0;
    end else begin
      if (consume) frame_valid <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (!last_slot) begin
              if (s_last) begin
                wr_idx  <= '0;
                err_len <= 1'b1;
              end else begin
                wr_idx <= wr_idx + 4'd1;
              end
            end else begin
              if (!s_last) err_len <= 1'b1;
              if (!frame_valid || consume) begin
                frame_real  <= commit_real;
                frame_im    <= commit_im;
                frame_valid <= 1'b1;
                wr_idx      <= '0;
                frame_count <= frame_count + 8'd1;
              end else begin
                state <= ST_WAIT;
              end
            end
          end
        end
        ST_WAIT: begin
          // Output bank frees up: promote the parked frame in the same edge
          if (consume) begin
            frame_real  <= commit_real;
            frame_im    <= commit_im;
            frame_valid <= 1'b1;
            wr_idx      <= '0;
            frame_count <= frame_count + 8'd1;
            state       <= ST_LOAD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: vector table for the early-s_last
// case, scoreboard of expected frames checked whenever a frame is consumed.
module tb_fft_frame_loader;

  localparam int DW = 16;
  localparam int NS = 16;
  localparam int FW = DW * NS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_real = '0;
  logic [DW-1:0] s_im = '0;
  logic          s_last = 1'b0;
  logic [FW-1:0] frame_real;
  logic [FW-1:0] frame_im;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [7:0]    frame_count;
  logic          err_len;

  fft_frame_loader #(.DATA_W(DW), .N(NS)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_im(s_im), .s_last(s_last),
    .frame_real(frame_real), .frame_im(frame_im), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_count(frame_count), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] re;
    logic [FW-1:0] im;
  } frame_t;

  typedef struct {
    logic          rst;
    logic          valid;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
    logic          fr;
    logic          exp_ready;
    logic          exp_fv;
    logic [7:0]    exp_cnt;
    logic          exp_err;
  } vec_t;

  frame_t exp_q[$];
  frame_t mon_f;
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A frame leaves the DUT at the edge after a negedge seeing valid && ready
  always @(negedge clk) begin
    if (!rst && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL unexpected_frame: got %0h expected none", frame_real);
      end else begin
        mon_f = exp_q.pop_front();
        checkOutput("frame_real", frame_real, mon_f.re);
        checkOutput("frame_im", frame_im, mon_f.im);
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
    int waited = 0;
    s_valid = 1'b1;
    s_real  = re;
    s_im    = im;
    s_last  = last;
    while (!s_ready && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL s_ready_timeout: got 0 expected 1");
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit with_last, input bit rnd, output frame_t f);
    logic [DW-1:0] r;
    f.re = '0;
    f.im = '0;
    for (int k = 0; k < NS; k++) begin
      r = rnd ? DW'($urandom) : base + DW'(k);
      f.re[k*DW +: DW] = r;
      f.im[k*DW +: DW] = -r;
    end
    exp_q.push_back(f);
    for (int k = 0; k < NS; k++)
      applyStimulus(f.re[k*DW +: DW], f.im[k*DW +: DW], with_last && (k == NS - 1));
  endtask

  task automatic pulse_ready();
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_in_reset", FW'(s_ready), FW'(1));
    rst = 1'b0;
    exp_q.delete();
  endtask

  vec_t   vecs[6];
  frame_t fa, fb;
  int     t0;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(posedge clk); #1;

    // Basic frame, output held
    do_reset();
    checkOutput("reset_state", FW'({s_ready, frame_valid, frame_count, err_len}), FW'({1'b1, 1'b0, 8'd0, 1'b0}));
    send_frame(16'd0, 1'b1, 1'b0, fa);
    checkOutput("b_fv", FW'(frame_valid), FW'(1));
    checkOutput("b_real3", FW'(frame_real[3*DW +: DW]), FW'(16'd3));
    checkOutput("b_im3", FW'(frame_im[3*DW +: DW]), FW'(16'hFFFD));
    checkOutput("b_cnt", FW'(frame_count), FW'(1));
    checkOutput("b_err", FW'(err_len), FW'(0));
    pulse_ready();
    checkOutput("consumed_fv", FW'(frame_valid), FW'(0));
    checkOutput("consumed_hold", frame_real, fa.re);

    // Continuous stream, consumer always ready
    frame_ready = 1'b1;
    t0 = cyc;
    for (int f = 0; f < 3; f++) begin
      send_frame(16'd0, 1'b1, 1'b1, fa);
      checkOutput($sformatf("stream_fv%0d", f), FW'(frame_valid), FW'(1));
    end
    checkOutput("stream_cycles", FW'(cyc - t0), FW'(48));
    checkOutput("stream_cnt", FW'(frame_count), FW'(4));
    @(posedge clk); #1;
    frame_ready = 1'b0;

    // Back-pressure: second frame parks in WAIT
    send_frame(16'h1000, 1'b1, 1'b0, fa);
    send_frame(16'h2000, 1'b1, 1'b0, fb);
    checkOutput("bp_ready", FW'(s_ready), FW'(0));
    checkOutput("bp_hold", frame_real, fa.re);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_hold2", frame_im, fa.im);
    pulse_ready();
    checkOutput("bp_next_real", frame_real, fb.re);
    checkOutput("bp_next_fv", FW'(frame_valid), FW'(1));
    checkOutput("bp_next_ready", FW'(s_ready), FW'(1));
    checkOutput("bp_cnt", FW'(frame_count), FW'(6));
    pulse_ready();

    // Reset while parked in WAIT
    send_frame(16'h3000, 1'b1, 1'b0, fa);
    send_frame(16'h4000, 1'b1, 1'b0, fb);
    checkOutput("wait_ready", FW'(s_ready), FW'(0));
    rst = 1'b1;
    #1;
    checkOutput("rst_ready_comb", FW'(s_ready), FW'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    checkOutput("rst_wait_state", FW'({s_ready, frame_valid, frame_count}), FW'({1'b1, 1'b0, 8'd0}));
    send_frame(16'h5000, 1'b1, 1'b0, fa);
    checkOutput("rst_new_real", frame_real, fa.re);
    pulse_ready();

    // Early s_last on the 5th sample, then a clean frame
    vecs[0] = '{1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
    for (int k = 1; k <= 5; k++)
      vecs[k] = '{1'b0, 1'b1, DW'(k), -DW'(k), (k == 5), 1'b0, 1'b1, 1'b0, 8'd0, (k == 5)};
    for (int i = 0; i < 6; i++) begin
      rst     = vecs[i].rst;
      s_valid = vecs[i].valid;
      s_real  = vecs[i].re;
      s_im    = vecs[i].im;
      s_last  = vecs[i].last;
      frame_ready = vecs[i].fr;
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d", i), FW'({s_ready, frame_valid, frame_count, err_len}),
                  FW'({vecs[i].exp_ready, vecs[i].exp_fv, vecs[i].exp_cnt, vecs[i].exp_err}));
    end
    rst = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    exp_q.delete();
    send_frame(16'd6, 1'b1, 1'b0, fa);
    checkOutput("early_cnt", FW'(frame_count), FW'(1));
    checkOutput("early_err", FW'(err_len), FW'(1));
    checkOutput("early_s0", FW'(frame_real[0 +: DW]), FW'(16'd6));
    pulse_ready();

    // Missing s_last still commits but flags the error
    do_reset();
    send_frame(16'h0700, 1'b0, 1'b0, fa);
    checkOutput("nolast_cnt", FW'(frame_count), FW'(1));
    checkOutput("nolast_err", FW'(err_len), FW'(1));
    pulse_ready();

    // Counter wrap over 257 frames
    do_reset();
    frame_ready = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      send_frame(DW'(i * 16), 1'b1, 1'b0, fa);
      if (i == 256) checkOutput("wrap_cnt256", FW'(frame_count), FW'(0));
    end
    checkOutput("wrap_cnt257", FW'(frame_count), FW'(1));
    checkOutput("wrap_err", FW'(err_len), FW'(0));
    repeat (2) @(posedge clk);
    #1;
    frame_ready = 1'b0;
    checkOutput("queue_empty", FW'(exp_q.size()), FW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
